// File: rtl/scmp_bus_ctl_pkg.sv
// Shared types and constants for the SC/MP external bus cycle controller.
package scmp_bus_ctl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StAddr,
    StGap,
    StStrb,
    StDone
  } bus_state_e;

  typedef struct packed {
    logic h;
    logic d;
    logic i;
    logic r;
  } bus_flags_t;

  localparam logic [7:0] AbortData = 8'hFF;

endpackage

// File: rtl/scmp_bus_ctl_if.sv
// SC/MP chip-pin bus: daisy-chain arbitration, strobes, address and data lines.
interface scmp_bus_ctl_if;

  logic        ext_breq;
  logic        ext_enin;
  logic        ext_enout;
  logic        ext_ads_n;
  logic        ext_rd_n;
  logic        ext_wr_n;
  logic        ext_hold_n;
  logic [11:0] ext_addr;
  logic [7:0]  ext_dout;
  logic        ext_doe;
  logic [7:0]  ext_din;

  modport master (
    output ext_breq, ext_enout, ext_ads_n, ext_rd_n, ext_wr_n, ext_addr, ext_dout, ext_doe,
    input  ext_enin, ext_hold_n, ext_din
  );

  modport slave (
    input  ext_breq, ext_enout, ext_ads_n, ext_rd_n, ext_wr_n, ext_addr, ext_dout, ext_doe,
    output ext_enin, ext_hold_n, ext_din
  );

endinterface

// File: rtl/scmp_bus_ctl_strobe_timer.sv
// Per-state phase counter and NHOLD extension counter, both saturating, with
// compare outputs for address-strobe length, minimum strobe and hold timeout.
module scmp_bus_ctl_strobe_timer #(
  parameter int unsigned AdsCycles   = 1,
  parameter int unsigned StrobeMin   = 2,
  parameter int unsigned HoldTimeout = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic hold_inc,
  output logic ads_done,
  output logic min_done,
  output logic timeout
);

  logic [3:0] phase_q, phase_d;
  logic [7:0] hold_q, hold_d;

  always_comb begin
    phase_d = phase_q;
    hold_d  = hold_q;
    if (clr) begin
      phase_d = '0;
      hold_d  = '0;
    end else begin
      if (phase_q != 4'hF) phase_d = phase_q + 4'd1;
      if (hold_inc && (hold_q != 8'hFF)) hold_d = hold_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      hold_q  <= '0;
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end

  // Phase 0 is the first cycle in a state, so "N cycles done" means phase >= N-1.
  assign ads_done = 32'(phase_q) >= (AdsCycles - 1);
  assign min_done = 32'(phase_q) >= (StrobeMin - 1);
  assign timeout  = (HoldTimeout != 0) && (32'(hold_q) >= HoldTimeout);

endmodule

// File: rtl/scmp_bus_ctl.sv
// Runs one SC/MP external bus cycle per microcode request: daisy-chain grant,
// address phase, gap, then read/write strobe with NHOLD wait-state extension.
module scmp_bus_ctl
  import scmp_bus_ctl_pkg::*;
#(
  parameter int unsigned AdsCycles   = 1,
  parameter int unsigned StrobeMin   = 2,
  parameter int unsigned HoldTimeout = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_ads,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic [3:0]    req_flags,
  input  logic [15:0]   addr_in,
  input  logic [7:0]    wdata_in,
  output logic          stall,
  output logic [7:0]    rdata,
  output logic          rdata_vld,
  output logic          bus_err,
  scmp_bus_ctl_if.master bus
);

  bus_state_e state_q, state_d;
  logic [15:0] addr_q;
  bus_flags_t  flags_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic        is_wr_q;
  logic        abort_q;

  logic accept, capture, abort, hold_inc;
  logic ads_done, min_done, timeout;

  scmp_bus_ctl_strobe_timer #(
    .AdsCycles  (AdsCycles),
    .StrobeMin  (StrobeMin),
    .HoldTimeout(HoldTimeout)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_d != state_q),
    .hold_inc(hold_inc),
    .ads_done(ads_done),
    .min_done(min_done),
    .timeout (timeout)
  );

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    hold_inc = 1'b0;
    unique case (state_q)
      StIdle: if (req_ads) begin
        accept  = 1'b1;
        state_d = StReq;
      end
      StReq:  if (bus.ext_enin) state_d = StAddr;
      StAddr: if (ads_done) state_d = StGap;
      StGap:  state_d = StStrb;
      StStrb: if (min_done) begin
        if (bus.ext_hold_n) begin
          capture = 1'b1;
          state_d = StDone;
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = StDone;
        end else begin
          hold_inc = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      flags_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      is_wr_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr_in;
        flags_q <= bus_flags_t'(req_flags);
        wdata_q <= wdata_in;
        // Conflicting or missing direction falls back to a read.
        is_wr_q <= req_wr & ~req_rd;
        abort_q <= 1'b0;
      end
      if (capture && !is_wr_q) rdata_q <= bus.ext_din;
      if (abort) begin
        abort_q <= 1'b1;
        if (!is_wr_q) rdata_q <= AbortData;
      end
    end
  end

  assign rdata        = rdata_q;
  assign bus.ext_addr = addr_q[11:0];

  always_comb begin
    stall         = 1'b0;
    bus_err       = 1'b0;
    rdata_vld     = 1'b0;
    bus.ext_breq  = 1'b0;
    bus.ext_enout = 1'b0;
    bus.ext_ads_n = 1'b1;
    bus.ext_rd_n  = 1'b1;
    bus.ext_wr_n  = 1'b1;
    bus.ext_doe   = 1'b0;
    bus.ext_dout  = 8'h00;
    unique case (state_q)
      StIdle: begin
        bus.ext_enout = bus.ext_enin;
        stall         = rst_n & req_ads;
        bus_err       = rst_n & req_ads & req_rd & req_wr;
      end
      StReq: begin
        stall        = 1'b1;
        bus.ext_breq = 1'b1;
      end
      StAddr, StGap: begin
        stall         = 1'b1;
        bus.ext_breq  = 1'b1;
        bus.ext_ads_n = (state_q != StAddr);
        bus.ext_doe   = 1'b1;
        bus.ext_dout  = {addr_q[15:12], flags_q};
      end
      StStrb: begin
        stall        = 1'b1;
        bus.ext_breq = 1'b1;
        bus.ext_rd_n = is_wr_q;
        bus.ext_wr_n = ~is_wr_q;
        bus.ext_doe  = is_wr_q;
        bus.ext_dout = is_wr_q ? wdata_q : 8'h00;
      end
      StDone: begin
        rdata_vld = ~is_wr_q;
        bus_err   = abort_q;
      end
      default: ;
    endcase
  end

endmodule
